// File: rtl/operand_fetch_stage_if.sv
// ============================================================================
// Module   : operand_fetch_stage_if
// Brief    : Instruction, operand, writeback and register-file bundle for the
//            operand fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int OPC_WIDTH  = 4
);
  logic                  InValid;
  logic                  InReady;
  logic [OPC_WIDTH-1:0]  InOpcode;
  logic [ADDR_WIDTH-1:0] InDest;
  logic [ADDR_WIDTH-1:0] InSrc1;
  logic [ADDR_WIDTH-1:0] InSrc2;

  logic                  OutValid;
  logic                  OutReady;
  logic [OPC_WIDTH-1:0]  OutOpcode;
  logic [ADDR_WIDTH-1:0] OutDest;
  logic [DATA_WIDTH-1:0] OutOperand1;
  logic [DATA_WIDTH-1:0] OutOperand2;

  logic                  WbValid;
  logic [ADDR_WIDTH-1:0] WbAddress;
  logic [DATA_WIDTH-1:0] WbValue;

  logic                  RfMode;
  logic [ADDR_WIDTH-1:0] RfWriteAddress;
  logic [DATA_WIDTH-1:0] RfWriteValue;
  logic [ADDR_WIDTH-1:0] RfReadAddress1;
  logic [ADDR_WIDTH-1:0] RfReadAddress2;
  logic [DATA_WIDTH-1:0] RfReadValue1;
  logic [DATA_WIDTH-1:0] RfReadValue2;

  // Environment side: decoder, execute stage and register file.
  modport master (
    output InValid, InOpcode, InDest, InSrc1, InSrc2,
    output OutReady, WbValid, WbAddress, WbValue,
    output RfReadValue1, RfReadValue2,
    input  InReady, OutValid, OutOpcode, OutDest, OutOperand1, OutOperand2,
    input  RfMode, RfWriteAddress, RfWriteValue, RfReadAddress1, RfReadAddress2
  );

  // Operand fetch stage side.
  modport slave (
    input  InValid, InOpcode, InDest, InSrc1, InSrc2,
    input  OutReady, WbValid, WbAddress, WbValue,
    input  RfReadValue1, RfReadValue2,
    output InReady, OutValid, OutOpcode, OutDest, OutOperand1, OutOperand2,
    output RfMode, RfWriteAddress, RfWriteValue, RfReadAddress1, RfReadAddress2
  );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// Module   : operand_fetch_stage
// Brief    : Reads instruction operands from the register file with writeback
//            priority and a pending-write scoreboard guarding RAW hazards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_fetch_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int OPC_WIDTH  = 4
) (
  input  wire logic              Clock,
  input  wire logic              Reset_n,
  operand_fetch_stage_if.slave   bus
);

  localparam int c_SB_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [c_SB_DEPTH-1:0] r_scoreboard;
  logic [c_SB_DEPTH-1:0] w_scoreboardNext;
  logic [OPC_WIDTH-1:0]  r_opcode;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [ADDR_WIDTH-1:0] r_src1;
  logic [ADDR_WIDTH-1:0] r_src2;
  logic [DATA_WIDTH-1:0] r_operand1;
  logic [DATA_WIDTH-1:0] r_operand2;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_issue;

  // The register file has a single port mode, so any writeback blocks reads.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.InValid) begin
          w_accept    = 1'b1;
          w_nextState = S_READ;
        end
      end
      S_READ: begin
        if (!(bus.WbValid || r_scoreboard[r_src1] || r_scoreboard[r_src2])) begin
          w_capture   = 1'b1;
          w_nextState = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.OutReady) begin
          w_issue     = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Set is applied after clear so an issue beats a same-address writeback.
  always_comb begin
    w_scoreboardNext = r_scoreboard;
    if (bus.WbValid) begin
      w_scoreboardNext[bus.WbAddress] = 1'b0;
    end
    if (w_issue) begin
      w_scoreboardNext[r_dest] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_scoreboard <= '0;
      r_opcode     <= '0;
      r_dest       <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_operand1   <= '0;
      r_operand2   <= '0;
    end else begin
      r_state      <= w_nextState;
      r_scoreboard <= w_scoreboardNext;
      if (w_accept) begin
        r_opcode <= bus.InOpcode;
        r_dest   <= bus.InDest;
        r_src1   <= bus.InSrc1;
        r_src2   <= bus.InSrc2;
      end
      if (w_capture) begin
        r_operand1 <= bus.RfReadValue1;
        r_operand2 <= bus.RfReadValue2;
      end
    end
  end

  assign bus.InReady        = (r_state == S_IDLE);
  assign bus.OutValid       = (r_state == S_HOLD);
  assign bus.OutOpcode      = r_opcode;
  assign bus.OutDest        = r_dest;
  assign bus.OutOperand1    = r_operand1;
  assign bus.OutOperand2    = r_operand2;

  assign bus.RfMode         = bus.WbValid;
  assign bus.RfWriteAddress = bus.WbAddress;
  assign bus.RfWriteValue   = bus.WbValue;
  assign bus.RfReadAddress1 = r_src1;
  assign bus.RfReadAddress2 = r_src2;

endmodule

`default_nettype wire
